// File: rtl/stream_in_fifo.sv
// rtl/stream_in_fifo.sv - first-word-fall-through elastic buffer ahead of the sample stream consumer
//
// Purpose:
//   Accepts words from a producer over a valid/ready handshake and presents
//   them, oldest first, to the consumer. Reports current occupancy and the
//   highest occupancy seen since reset.
//
// Ports:
//   clk              rising-edge clock
//   reset_n          synchronous active-low reset
//   up_valid         producer offers up_data
//   up_ready         FIFO can accept a word this cycle
//   up_data          producer word
//   stream_in_valid  head word present on stream_in_data
//   stream_in_ready  consumer takes the head word
//   stream_in_data   head word (first-word-fall-through)
//   level            current occupancy, 0..DEPTH
//   high_water       maximum occupancy since reset
module stream_in_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [DATA_WIDTH-1:0]   up_data,
  output logic                    stream_in_valid,
  input  logic                    stream_in_ready,
  output logic [DATA_WIDTH-1:0]   stream_in_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  high_water
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level_q;
  logic [AW:0]           high_water_q;
  logic [AW:0]           level_next;
  logic                  push;
  logic                  pop;

  // Handshake flags come only from the registered level, so there is no
  // combinational path between the two sides of the buffer. When full,
  // a same-cycle pop does not open up_ready.
  assign up_ready        = (level_q != FULL_LEVEL);
  assign stream_in_valid = (level_q != '0);

  assign push = up_valid & up_ready;
  assign pop  = stream_in_valid & stream_in_ready;

  assign stream_in_data = mem[rd_ptr];
  assign level          = level_q;
  assign high_water     = high_water_q;

  always_comb begin
    level_next = level_q;
    case ({push, pop})
      2'b10:   level_next = level_q + LEVEL_ONE;
      2'b01:   level_next = level_q - LEVEL_ONE;
      default: level_next = level_q;
    endcase
  end

  // Storage is deliberately left out of reset; only pointers and counters clear.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= up_data;
    end
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      high_water_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level_q <= level_next;
      if (level_next > high_water_q) begin
        high_water_q <= level_next;
      end
    end
  end

endmodule

// File: tb/tb_stream_in_fifo.sv
// tb/tb_stream_in_fifo.sv - self-checking bench for stream_in_fifo
module tb_stream_in_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          up_valid;
  logic          up_ready;
  logic [DW-1:0] up_data;
  logic          stream_in_valid;
  logic          stream_in_ready;
  logic [DW-1:0] stream_in_data;
  logic [2:0]    level;
  logic [2:0]    high_water;

  stream_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .up_valid        (up_valid),
    .up_ready        (up_ready),
    .up_data         (up_data),
    .stream_in_valid (stream_in_valid),
    .stream_in_ready (stream_in_ready),
    .stream_in_data  (stream_in_data),
    .level           (level),
    .high_water      (high_water)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          uv;
    logic [DW-1:0] ud;
    logic          rdy;
    logic [2:0]    exp_level;
    logic          exp_up_ready;
    logic          exp_valid;
    logic [2:0]    exp_hw;
  } vec_t;

  int            pass_cnt = 0;
  int            total_cnt = 0;
  logic [DW-1:0] sb [$];
  int            model_hw = 0;
  logic [DW-1:0] next_seq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the queue
  // model, advance the model across the edge, then check level/high_water.
  task automatic step(input logic uv, input logic [DW-1:0] ud, input logic rdy);
    bit do_push;
    bit do_pop;
    up_valid        = uv;
    up_data         = ud;
    stream_in_ready = rdy;
    #1;
    chk("up_ready", 32'(up_ready), 32'(sb.size() != DEPTH));
    chk("stream_in_valid", 32'(stream_in_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("stream_in_data", 32'(stream_in_data), 32'(sb[0]));
    end
    do_push = uv && (sb.size() != DEPTH);
    do_pop  = rdy && (sb.size() != 0);
    if (do_pop) begin
      void'(sb.pop_front());
    end
    if (do_push) begin
      sb.push_back(ud);
    end
    if (sb.size() > model_hw) begin
      model_hw = sb.size();
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(sb.size()));
    chk("high_water", 32'(high_water), 32'(model_hw));
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    up_valid        = 1'b0;
    stream_in_ready = 1'b0;
    up_data         = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    model_hw = 0;
    chk("reset up_ready", 32'(up_ready), 32'd1);
    chk("reset stream_in_valid", 32'(stream_in_valid), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset high_water", 32'(high_water), 32'd0);
  endtask

  vec_t vecs [$];

  initial begin
    // Single word hold, pop, fill to full, stall at full, full+pop, drain.
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 3'd1, 1'b1, 1'b1, 3'd1});
    for (int i = 0; i < 5; i++) begin
      vecs.push_back('{1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b1, 3'd1});
    end
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 1'b1, 3'd1});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 3'd2, 1'b1, 1'b1, 3'd2});
    vecs.push_back('{1'b1, 8'h03, 1'b0, 3'd3, 1'b1, 1'b1, 3'd3});
    vecs.push_back('{1'b1, 8'h04, 1'b0, 3'd4, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 3'd4, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 3'd4, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 8'h05, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4});
    vecs.push_back('{1'b1, 8'h05, 1'b0, 3'd4, 1'b0, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 3'd4});

    // Reset from empty.
    do_reset();

    // Reset while holding three words.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("pre-reset level", 32'(level), 32'd3);
    do_reset();

    // Table-driven directed sequence.
    foreach (vecs[i]) begin
      step(vecs[i].uv, vecs[i].ud, vecs[i].rdy);
      chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d up_ready", i), 32'(up_ready), 32'(vecs[i].exp_up_ready));
      chk($sformatf("vec%0d valid", i), 32'(stream_in_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d high_water", i), 32'(high_water), 32'(vecs[i].exp_hw));
    end

    // Continuous streaming 00..FF with ready held high.
    do_reset();
    next_seq = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (stream_in_valid === 1'b1) begin
        chk("stream order", 32'(stream_in_data), 32'(next_seq));
        next_seq = next_seq + 8'h01;
      end
      step(1'b1, 8'(i), 1'b1);
      chk("stream level", 32'(level), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stream drained level", 32'(level), 32'd0);
    chk("stream count", 32'(next_seq), 32'hFF);
    chk("stream high_water", 32'(high_water), 32'd1);

    // Random valid/ready traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 8'h00, 1'b1);
    end
    chk("random drained", 32'(level), 32'd0);
    chk("random high_water", 32'(high_water), 32'(model_hw));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
